sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2; SRAM cycles spent on each 16-bit half-word access (legal range 1..15).
REQ-002 Parameter SRAM_BASE, default 1024; byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-low.
REQ-005 wr_en  input  1  store request from the MEM stage.
REQ-006 rd_en  input  1  load request from the MEM stage.
REQ-007 address  input  32  byte address (ALU result).
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data; feeds the MEM/WB register mem input.
REQ-010 ready  output  1  high = no access in flight; the pipeline freeze input is driven from ~ready.
REQ-011 sram_dq  inout  16  SRAM data bus.
REQ-012 sram_addr  output  18  SRAM half-word address.
REQ-013 sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM controls.

Function
REQ-014 States: IDLE, ACC_LO, ACC_HI, DONE.
- IDLE -> ACC_LO when wr_en or rd_en is high.
- ACC_LO -> ACC_HI after ACCESS_CYCLES cycles.
- ACC_HI -> DONE after ACCESS_CYCLES cycles.
- DONE -> IDLE unconditionally.
REQ-015 A 4-bit wait counter clears on every state entry and increments in ACC_LO and ACC_HI; the state exits when the counter equals ACCESS_CYCLES-1.
REQ-016 Ready timing:
- In IDLE, ready = ~(wr_en | rd_en), combinational, so the requesting cycle already freezes.
- ready is 0 in ACC_LO and ACC_HI.
- ready is 1 in DONE.
- Freeze length per access = 2*ACCESS_CYCLES+1 cycles (5 at default).
REQ-017 Word address = (address - SRAM_BASE) >> 2, modulo 2^32; sram_addr = {word_addr[16:0], 0} in ACC_LO and {word_addr[16:0], 1} in ACC_HI; higher address bits are ignored (wrap-around).
REQ-018 Request inputs are latched into internal registers on the IDLE -> ACC_LO edge; input changes during the access have no effect.
REQ-019 Write:
- sram_we_n is 0 throughout ACC_LO and ACC_HI.
- sram_dq drives write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI.
REQ-020 Read:
- sram_we_n is 1 and sram_dq is high-Z.
- sram_dq is sampled into read_data[15:0] on the last ACC_LO cycle and into read_data[31:16] on the last ACC_HI cycle.
REQ-021 read_data holds its value until the next read completes; writes do not change it.
REQ-022 When wr_en and rd_en are both high, the access is a write.
REQ-023 sram_ce_n, sram_ub_n and sram_lb_n are 0 in ACC states and 1 otherwise; sram_oe_n is 0 only during a read access.
REQ-024 In IDLE and DONE: sram_dq is high-Z and sram_we_n is 1.
REQ-025 After DONE, the controller returns to IDLE, so a request held through DONE is served once and the next instruction's request starts a new access.

Reset
REQ-026 While rst = 0:
- state = IDLE and counter = 0.
- ready = 1 (given no request) and read_data = 0.
- sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n and sram_lb_n = 1.
- sram_dq is high-Z.
REQ-027 Reset asserted mid-access aborts it immediately; a partially written word is not completed or retried.

Structure
REQ-028 Package mem_ctrl_pkg holds:
- the state enumeration;
- SRAM_BASE and the default ACCESS_CYCLES;
- the SRAM address width (18).
REQ-029 Single module; the tri-state bus is driven as sram_dq = drive_en ? out_half : 'z.
REQ-030 No sub-module; the counter is inline.

Verification
REQ-031 Write then read, ACCESS_CYCLES=2: write address 1024, data 0xDEADBEEF; then read address 1024 -> each access has ready low 5 cycles; the SRAM model holds 0xBEEF at half-word 0 and 0xDEAD at half-word 1; read_data = 0xDEADBEEF.
REQ-032 Address mapping: write address 1032, data 0x12345678 -> writes go to sram_addr 4 (0x5678) and 5 (0x1234).
REQ-033 Both wr_en and rd_en high at address 1024 with 0xA5A5A5A5 -> a write occurs; read_data keeps its prior value.
REQ-034 Reset pulse in the second ACC_HI cycle of a write -> next cycle: state IDLE, sram_we_n = 1, dq high-Z, read_data = 0, ready = 1.
REQ-035 Back-to-back reads at 1024 then 1028 with requests held through DONE -> exactly two 5-cycle freezes, one DONE cycle between them, and correct data for each.
REQ-036 ACCESS_CYCLES=1 -> freeze = 3 cycles per access with correct data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the access state encoding, the address map and the bus widths.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        DONE
    } state_t;

    localparam int          DEFAULT_ACCESS_CYCLES = 2;
    localparam logic [31:0] SRAM_BASE             = 32'd1024;
    localparam int          SRAM_ADDR_W           = 18;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage controller for a 16-bit asynchronous SRAM: each 32-bit access is
// split into a low and a high half-word, and the pipeline is frozen via ~ready.
module sram_controller
    import mem_ctrl_pkg::*;
#(
    parameter int          ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
    parameter logic [31:0] SRAM_BASE     = mem_ctrl_pkg::SRAM_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        cnt_last;
    logic        req;
    logic        in_acc;
    logic        is_write;
    logic [16:0] word_addr;
    logic [31:0] wdata;
    logic [15:0] rd_lo;
    logic [31:0] addr_off;
    logic        drive_en;
    logic [15:0] out_half;
    logic        unused_addr_bits;

    assign req      = wr_en | rd_en;
    assign cnt_last = (wait_cnt == LAST_CNT);
    assign in_acc   = (state == ACC_LO) || (state == ACC_HI);

    // Offset from the SRAM window; anything above the 17-bit word index wraps.
    assign addr_off         = address - SRAM_BASE;
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req)      state_next = ACC_LO;
            ACC_LO:  if (cnt_last) state_next = ACC_HI;
            ACC_HI:  if (cnt_last) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Counter restarts on every state entry so each half gets a full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (in_acc) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_write  <= 1'b0;
            word_addr <= '0;
            wdata     <= '0;
        end else if (state == IDLE && req) begin
            is_write  <= wr_en;
            word_addr <= addr_off[18:2];
            wdata     <= write_data;
        end
    end

    // Low half is staged so read_data only changes once the whole word is in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_lo     <= '0;
            read_data <= '0;
        end else if (!is_write && cnt_last) begin
            if (state == ACC_LO) begin
                rd_lo <= sram_dq;
            end else if (state == ACC_HI) begin
                read_data <= {sram_dq, rd_lo};
            end
        end
    end

    assign drive_en  = in_acc && is_write;
    assign out_half  = (state == ACC_HI) ? wdata[31:16] : wdata[15:0];
    assign sram_dq   = drive_en ? out_half : 'z;
    assign sram_addr = {word_addr, (state == ACC_HI)};

    always_comb begin
        ready     = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_ce_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        case (state)
            IDLE:    ready = ~req;
            ACC_LO,
            ACC_HI: begin
                ready     = 1'b0;
                sram_we_n = ~is_write;
                sram_oe_n = is_write;
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b1;
        endcase
    end

endmodule
